// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level game sequencer.
// Walks TITLE / STAFF / STAGE1..3 / SUCCESS1..3 / FAIL from button pulses
// and gameplay events. A private 1 s prescaler provides elapsed_s and tick_1s,
// which drive the per-stage time limit and the success-screen auto-advance.
// Optional feature macro: GAME_PAUSE_EN (pause toggle inside stages).
module game_flow_ctrl #(
  parameter int CLK_HZ         = 100000000,
  parameter int SUCCESS_HOLD_S = 3,
  parameter int STAGE_LIMIT_S  = 300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_staff,
  input  logic       btn_back,
  input  logic       btn_pause,
  input  logic       stage_clear,
  input  logic       player_dead,
  output logic [3:0] state,
  output logic [1:0] stage_num,
  output logic [1:0] fail_cause,
  output logic       tick_1s,
  output logic [9:0] elapsed_s,
  output logic       paused
);

  typedef enum logic [3:0] {
    S_TITLE    = 4'd0,
    S_STAFF    = 4'd1,
    S_STAGE1   = 4'd2,
    S_SUCCESS1 = 4'd3,
    S_STAGE2   = 4'd4,
    S_SUCCESS2 = 4'd5,
    S_STAGE3   = 4'd6,
    S_SUCCESS3 = 4'd7,
    S_FAIL     = 4'd8
  } state_t;

  localparam int              PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [9:0]      HOLD_V    = 10'(SUCCESS_HOLD_S);
  localparam logic [9:0]      LIMIT_V   = 10'(STAGE_LIMIT_S);

  state_t        state_q, state_d;
  logic [1:0]    stage_num_q, stage_num_d;
  logic [1:0]    fail_cause_q, fail_cause_d;
  logic          tick_q, tick_d;
  logic [9:0]    elapsed_q, elapsed_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          paused_q, paused_d;

  logic          wrap;
  logic [9:0]    elapsed_inc;

`ifndef GAME_PAUSE_EN
  logic unused_pause;
  assign unused_pause = btn_pause;
`endif

  // One-second boundary detection and the saturated next elapsed value
  always_comb begin
    wrap        = !paused_q && (presc_q == PRESC_MAX);
    elapsed_inc = (elapsed_q == 10'd1023) ? elapsed_q : elapsed_q + 10'd1;
  end

  // Next-state, stage bookkeeping and pause flag, first matching rule wins
  always_comb begin
    state_d      = state_q;
    stage_num_d  = stage_num_q;
    fail_cause_d = fail_cause_q;
    paused_d     = paused_q;
    case (state_q)
      S_TITLE: begin
        if (btn_start) begin
          state_d      = S_STAGE1;
          stage_num_d  = 2'd1;
          fail_cause_d = 2'd0;
        end else if (btn_staff) begin
          state_d = S_STAFF;
        end
      end
      S_STAFF: begin
        if (btn_back) state_d = S_TITLE;
      end
      S_STAGE1, S_STAGE2, S_STAGE3: begin
        if (paused_q) begin
          if (btn_back) begin
            state_d      = S_TITLE;
            stage_num_d  = 2'd0;
            fail_cause_d = 2'd0;
          end
        end else if (player_dead) begin
          state_d      = S_FAIL;
          fail_cause_d = 2'd1;
        end else if (stage_clear) begin
          state_d = state_t'(state_q + 4'd1);
        end else if (wrap && (elapsed_inc == LIMIT_V)) begin
          state_d      = S_FAIL;
          fail_cause_d = 2'd2;
        end
`ifdef GAME_PAUSE_EN
        if (btn_pause) paused_d = !paused_q;
`endif
      end
      S_SUCCESS1, S_SUCCESS2: begin
        if (btn_start || (wrap && (elapsed_inc == HOLD_V))) begin
          state_d     = state_t'(state_q + 4'd1);
          stage_num_d = stage_num_q + 2'd1;
        end
      end
      S_SUCCESS3: begin
        if (btn_start || btn_back) state_d = S_TITLE;
      end
      S_FAIL: begin
        if (btn_start) begin
          fail_cause_d = 2'd0;
          case (stage_num_q)
            2'd2:    state_d = S_STAGE2;
            2'd3:    state_d = S_STAGE3;
            default: begin
              state_d     = S_STAGE1;
              stage_num_d = 2'd1;
            end
          endcase
        end else if (btn_back) begin
          state_d      = S_TITLE;
          stage_num_d  = 2'd0;
          fail_cause_d = 2'd0;
        end
      end
      default: state_d = S_TITLE;
    endcase
    if (state_d != state_q) paused_d = 1'b0;
  end

  // Prescaler and elapsed-seconds counter, restarted by every state change
  always_comb begin
    presc_d   = presc_q;
    elapsed_d = elapsed_q;
    tick_d    = 1'b0;
    if (state_d != state_q) begin
      presc_d   = '0;
      elapsed_d = '0;
    end else if (!paused_q) begin
      if (wrap) begin
        presc_d   = '0;
        elapsed_d = elapsed_inc;
        tick_d    = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_TITLE;
      stage_num_q  <= 2'd0;
      fail_cause_q <= 2'd0;
      tick_q       <= 1'b0;
      elapsed_q    <= 10'd0;
      presc_q      <= '0;
      paused_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_num_q  <= stage_num_d;
      fail_cause_q <= fail_cause_d;
      tick_q       <= tick_d;
      elapsed_q    <= elapsed_d;
      presc_q      <= presc_d;
      paused_q     <= paused_d;
    end
  end

  assign state      = state_q;
  assign stage_num  = stage_num_q;
  assign fail_cause = fail_cause_q;
  assign tick_1s    = tick_q;
  assign elapsed_s  = elapsed_q;
  assign paused     = paused_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed scenarios plus random pulses, checked every
// cycle against a cycle-counting reference model of the game flow.
module tb_game_flow_ctrl;

  localparam int CLK_HZ = 10;
  localparam int HOLD   = 3;
  localparam int LIMIT  = 5;
`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start = 1'b0, btn_staff = 1'b0, btn_back = 1'b0, btn_pause = 1'b0;
  logic       stage_clear = 1'b0, player_dead = 1'b0;
  logic [3:0] state;
  logic [1:0] stage_num, fail_cause;
  logic       tick_1s, paused;
  logic [9:0] elapsed_s;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  int m_state = 0, m_stage = 0, m_cause = 0, m_tick = 0;
  int m_elapsed = 0, m_paused = 0, m_active = 0;

  // Free-running clock
  always #5 clk = ~clk;

  game_flow_ctrl #(
    .CLK_HZ(CLK_HZ), .SUCCESS_HOLD_S(HOLD), .STAGE_LIMIT_S(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_start(btn_start), .btn_staff(btn_staff), .btn_back(btn_back),
    .btn_pause(btn_pause), .stage_clear(stage_clear), .player_dead(player_dead),
    .state(state), .stage_num(stage_num), .fail_cause(fail_cause),
    .tick_1s(tick_1s), .elapsed_s(elapsed_s), .paused(paused)
  );

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // Reference model: counts unpaused cycles spent in the current state and
  // derives seconds and ticks from that count
  always @(posedge clk) begin : ref_model
    int  ns, nstage, ncause, np, newel;
    bit  wrap;
    if (!rst_n) begin
      m_state = 0; m_stage = 0; m_cause = 0; m_tick = 0;
      m_elapsed = 0; m_paused = 0; m_active = 0;
    end else begin
      ns = m_state; nstage = m_stage; ncause = m_cause; np = m_paused;
      wrap  = (m_paused == 0) && (((m_active + 1) % CLK_HZ) == 0);
      newel = (m_active + 1) / CLK_HZ;
      if (newel > 1023) newel = 1023;
      case (m_state)
        0: if (btn_start) begin ns = 2; nstage = 1; ncause = 0; end
           else if (btn_staff) ns = 1;
        1: if (btn_back) ns = 0;
        2, 4, 6: begin
          if (m_paused != 0) begin
            if (btn_back) begin ns = 0; nstage = 0; ncause = 0; end
          end else if (player_dead) begin ns = 8; ncause = 1; end
          else if (stage_clear) ns = m_state + 1;
          else if (wrap && newel == LIMIT) begin ns = 8; ncause = 2; end
          if (PAUSE_EN && btn_pause) np = 1 - m_paused;
        end
        3, 5: if (btn_start || (wrap && newel == HOLD)) begin
          ns = m_state + 1; nstage = m_stage + 1;
        end
        7: if (btn_start || btn_back) ns = 0;
        8: if (btn_start) begin ns = 2 * m_stage; ncause = 0; end
           else if (btn_back) begin ns = 0; nstage = 0; ncause = 0; end
        default: ns = 0;
      endcase
      if (ns != m_state) begin
        np = 0; m_active = 0; m_tick = 0;
      end else if (m_paused == 0) begin
        m_active++;
        m_tick = ((m_active % CLK_HZ) == 0) ? 1 : 0;
      end else begin
        m_tick = 0;
      end
      m_elapsed = (m_active / CLK_HZ > 1023) ? 1023 : m_active / CLK_HZ;
      m_state = ns; m_stage = nstage; m_cause = ncause; m_paused = np;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model_state", state, m_state);
      checkOutput("model_stage_num", stage_num, m_stage);
      checkOutput("model_fail_cause", fail_cause, m_cause);
      checkOutput("model_tick_1s", tick_1s, m_tick);
      checkOutput("model_elapsed_s", elapsed_s, m_elapsed);
      checkOutput("model_paused", paused, m_paused);
    end
  end

  // Drive one single-cycle pulse set, returning at the next falling edge
  task automatic applyStimulus(input bit s, input bit st, input bit b,
                               input bit p, input bit c, input bit d);
    btn_start = s; btn_staff = st; btn_back = b; btn_pause = p;
    stage_clear = c; player_dead = d;
    @(negedge clk);
    btn_start = 0; btn_staff = 0; btn_back = 0; btn_pause = 0;
    stage_clear = 0; player_dead = 0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    rst_n = 0;
    waitCycles(3);
    check_en = 1;
    checkOutput("reset_state", state, 0);
    checkOutput("reset_elapsed", elapsed_s, 0);
    rst_n = 1;

    // Start, tick cadence, timeout
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("start_state", state, 2);
    checkOutput("start_stage_num", stage_num, 1);
    waitCycles(10);
    checkOutput("first_tick", tick_1s, 1);
    checkOutput("first_tick_elapsed", elapsed_s, 1);
    waitCycles(39);
    checkOutput("before_timeout_state", state, 2);
    checkOutput("before_timeout_elapsed", elapsed_s, 4);
    waitCycles(1);
    checkOutput("timeout_state", state, 8);
    checkOutput("timeout_cause", fail_cause, 2);

    // Retry, death beats clear, retry again
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("retry_state", state, 2);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("dead_state", state, 8);
    checkOutput("dead_cause", fail_cause, 1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("retry2_state", state, 2);
    checkOutput("retry2_cause", fail_cause, 0);
    checkOutput("retry2_elapsed", elapsed_s, 0);

    // Success hold auto-advance, manual advance, SUCCESS3 has no auto-advance
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("success1_state", state, 3);
    waitCycles(29);
    checkOutput("hold_state", state, 3);
    waitCycles(1);
    checkOutput("auto_stage2_state", state, 4);
    checkOutput("auto_stage2_num", stage_num, 2);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("success2_state", state, 5);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("stage3_state", state, 6);
    checkOutput("stage3_num", stage_num, 3);
    applyStimulus(0, 0, 0, 0, 1, 0);
    waitCycles(100);
    checkOutput("success3_hold_state", state, 7);
    checkOutput("success3_elapsed", elapsed_s, 10);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("success3_back_state", state, 0);

    // Staff screen and start/staff priority
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("staff_state", state, 1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("staff_ignore_start", state, 1);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("staff_back_state", state, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("start_beats_staff", state, 2);

    // Reset mid-STAGE2
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    waitCycles(20);
    checkOutput("stage2_elapsed", elapsed_s, 2);
    rst_n = 0;
    waitCycles(1);
    rst_n = 1;
    checkOutput("midreset_state", state, 0);
    checkOutput("midreset_stage_num", stage_num, 0);
    checkOutput("midreset_elapsed", elapsed_s, 0);

    // Pause behaviour
    applyStimulus(1, 0, 0, 0, 0, 0);
    waitCycles(20);
`ifdef GAME_PAUSE_EN
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("pause_set", paused, 1);
    for (int i = 0; i < 50; i++) applyStimulus(0, 0, 0, 0, i[0], !i[0]);
    checkOutput("paused_state", state, 2);
    checkOutput("paused_elapsed", elapsed_s, 2);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("pause_clear", paused, 0);
    waitCycles(9);
    checkOutput("resume_elapsed", elapsed_s, 3);
    checkOutput("resume_tick", tick_1s, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("paused_back_state", state, 0);
    checkOutput("paused_back_flag", paused, 0);
`else
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("nopause_flag", paused, 0);
    checkOutput("nopause_state", state, 2);
`endif

    // Random pulses with occasional resets
    for (int i = 0; i < 4000; i++) begin
      btn_start   = ($urandom_range(0, 29) == 0);
      btn_staff   = ($urandom_range(0, 29) == 0);
      btn_back    = ($urandom_range(0, 29) == 0);
      btn_pause   = ($urandom_range(0, 39) == 0);
      stage_clear = ($urandom_range(0, 39) == 0);
      player_dead = ($urandom_range(0, 59) == 0);
      rst_n       = ($urandom_range(0, 499) != 0);
      @(negedge clk);
    end
    btn_start = 0; btn_staff = 0; btn_back = 0; btn_pause = 0;
    stage_clear = 0; player_dead = 0; rst_n = 1;
    waitCycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Top-level game sequencer that produces the 4-bit `state` bus consumed by the stage timer, the display and the stage logic. It advances through title, staff, three stages with success screens, and fail, driven by one-cycle button pulses and gameplay events. It also enforces a per-stage time limit with its own 1 s prescaler, and auto-advances success screens after a hold time.

Parameters:
CLK_HZ, 100000000, clock cycles per second; the prescaler wraps at CLK_HZ-1
SUCCESS_HOLD_S, 3, seconds SUCCESS1/SUCCESS2 are held before auto-advancing
STAGE_LIMIT_S, 300, seconds allowed per stage before a forced FAIL (1..1023)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
btn_start  in  1  start/confirm; one-cycle pulse
btn_staff  in  1  open staff screen; one-cycle pulse
btn_back  in  1  back to title; one-cycle pulse
btn_pause  in  1  pause toggle; one-cycle pulse (used only with PAUSE_EN)
stage_clear  in  1  current stage cleared; pulse
player_dead  in  1  player died; pulse
state  out  4  TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8
stage_num  out  2  last stage entered: 1..3, 0 before the first stage
fail_cause  out  2  0 none, 1 death, 2 timeout; valid in FAIL
tick_1s  out  1  one-cycle pulse each elapsed second in the current state
elapsed_s  out  10  seconds spent in the current state; saturates at 1023
paused  out  1  pause flag

Behaviour:
- Reset: when rst_n=0 at a clk edge, all outputs take these values:
  - state=TITLE, stage_num=0, fail_cause=0.
  - tick_1s=0, elapsed_s=0, paused=0.
  - Prescaler=0.
- All outputs are registered. A transition is visible on `state` one cycle after the qualifying input.
- Any state change in the same cycle clears the prescaler, sets elapsed_s=0 and forces tick_1s=0.
- Prescaler counts 0..CLK_HZ-1.
  - At CLK_HZ-1 it wraps to 0.
  - In that same cycle it pulses tick_1s and increments elapsed_s (saturating at 1023).
- Transitions are evaluated in the priority order listed; the first match wins.
  - TITLE:
    - btn_start → STAGE1, stage_num=1, fail_cause=0.
    - Otherwise btn_staff → STAFF.
  - STAFF: btn_back → TITLE. All other inputs are ignored.
  - STAGEn:
    - player_dead → FAIL, fail_cause=1.
    - Otherwise stage_clear → SUCCESSn.
    - Otherwise a tick_1s that brings elapsed_s to STAGE_LIMIT_S → FAIL, fail_cause=2.
    - Buttons other than btn_pause are ignored.
  - SUCCESS1/SUCCESS2:
    - btn_start → next stage.
    - Otherwise a tick_1s that brings elapsed_s to SUCCESS_HOLD_S → next stage.
    - Entering the next stage sets stage_num to n+1.
  - SUCCESS3:
    - btn_start or btn_back → TITLE. There is no auto-advance.
    - stage_num is held.
  - FAIL:
    - btn_start → STAGE(stage_num), i.e. retry the same stage; fail_cause=0.
    - Otherwise btn_back → TITLE, stage_num=0, fail_cause=0.
- stage_clear and player_dead outside STAGE states are ignored.
- Reset asserted mid-stage or mid-hold overrides everything in that cycle.
- Illegal encodings 9..15 return to TITLE on the next clock.

Optional Feature:
GAME_PAUSE_EN
- Defined:
  - btn_pause toggles `paused` only while in a STAGE state.
  - While paused=1:
    - Prescaler and elapsed_s freeze, and tick_1s stays 0.
    - stage_clear, player_dead and timeout are ignored.
    - btn_back → TITLE and clears paused; stage_num=0, fail_cause=0.
  - Leaving a STAGE state by any path clears paused.
- Undefined: btn_pause is ignored and paused is constant 0. The port list is unchanged.

Test Plan:
1. Sim with CLK_HZ=10, STAGE_LIMIT_S=5.
   - Reset, then btn_start → state=2, stage_num=1 next cycle.
   - Then no events → tick_1s every 10 cycles; on the 5th tick state=8, fail_cause=2.
2. In STAGE1, player_dead and stage_clear in the same cycle → state=8, fail_cause=1.
   - Then btn_start → state=2, fail_cause=0, elapsed_s=0.
3. Clear STAGE1 → state=3.
   - Idle 3 ticks (SUCCESS_HOLD_S=3) → state=4, stage_num=2.
   - Repeat via btn_start in SUCCESS2 → state=6, stage_num=3.
   - Clear → state=7; wait 10 s → still 7; btn_back → state=0.
4. TITLE: btn_staff → 1; btn_start in STAFF → stays 1; btn_back → 0.
   - btn_start and btn_staff together in TITLE → state=2.
5. Assert rst_n=0 mid-STAGE2 at elapsed_s=2 → next cycle all outputs at reset values and state=0.
6. With GAME_PAUSE_EN, in STAGE1 at elapsed_s=2:
   - btn_pause → paused=1.
   - 50 cycles of stage_clear and player_dead pulses → state stays 2 and elapsed_s stays 2.
   - btn_pause → paused=0; counting resumes.
